// File: rtl/encryption_stream_ctrl.sv
// Streaming ECB/CBC/CTR wrapper around the combinational encryption core.
// CTR mode and its counter are present only when ENC_CTR_MODE_EN is defined.

// Behavioural stand-in for the shared encryption core so this file elaborates on its own.
module encryption (
  input  logic [127:0] in,
  input  logic [255:0] sbox_seed,
  input  logic [255:0] key,
  output logic [127:0] out
);
  logic [127:0] mix;
  logic [127:0] rot;

  assign mix = in ^ key[127:0];
  assign rot = {mix[118:0], mix[127:119]};
  assign out = (rot + sbox_seed[127:0]) ^ key[255:128] ^ sbox_seed[255:128];
endmodule

module encryption_stream_ctrl #(
  parameter int CORE_LAT = 1,
  parameter int CTR_W    = 32,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_mode,
  input  logic [255:0]     cfg_key,
  input  logic [255:0]     cfg_seed,
  input  logic [127:0]     cfg_iv,
  output logic             cfg_err,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] blk_count
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;

  state_t              state;
  logic [1:0]          mode_q;
  logic [255:0]        key_q;
  logic [255:0]        seed_q;
  logic [127:0]        iv_q;
  logic [127:0]        chain_q;
`ifdef ENC_CTR_MODE_EN
  logic [CTR_W-1:0]    ctr_q;
`endif
  logic [CORE_LAT-1:0] pv;
  logic [CORE_LAT-1:0] pl;
  logic [127:0]        pd [CORE_LAT];

  logic [127:0] core_in;
  logic [127:0] core_out;
  logic [127:0] stage_in;
  logic         advance;
  logic         in_fire;
  logic         out_fire;
  logic         mode_ok;

  encryption u_core (
    .in        (core_in),
    .sbox_seed (seed_q),
    .key       (key_q),
    .out       (core_out)
  );

  assign advance   = !pv[CORE_LAT-1] || out_ready;
  // CBC chains on the previous ciphertext, so only one block may be outstanding.
  assign in_ready  = (state == S_RUN) && advance && !((mode_q == M_CBC) && (|pv));
  assign in_fire   = in_valid && in_ready;
  assign out_valid = pv[CORE_LAT-1];
  assign out_data  = pd[CORE_LAT-1];
  assign out_last  = pl[CORE_LAT-1];
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != S_IDLE);

  always_comb begin
    case (cfg_mode)
      M_ECB, M_CBC: mode_ok = 1'b1;
`ifdef ENC_CTR_MODE_EN
      M_CTR:        mode_ok = 1'b1;
`endif
      default:      mode_ok = 1'b0;
    endcase
  end

  // CTR folds in_data into the keystream at stage 1, so the plaintext rides with its block.
  always_comb begin
    core_in  = in_data;
    stage_in = core_out;
    case (mode_q)
      M_CBC: core_in = in_data ^ chain_q;
`ifdef ENC_CTR_MODE_EN
      M_CTR: begin
        core_in  = {iv_q[127:CTR_W], ctr_q};
        stage_in = core_out ^ in_data;
      end
`endif
      default: core_in = in_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= M_ECB;
      key_q     <= '0;
      seed_q    <= '0;
      iv_q      <= '0;
      chain_q   <= '0;
`ifdef ENC_CTR_MODE_EN
      ctr_q     <= '0;
`endif
      pv        <= '0;
      pl        <= '0;
      for (int i = 0; i < CORE_LAT; i++) pd[i] <= '0;
      cfg_err   <= 1'b0;
      blk_count <= '0;
    end else begin
      if (advance) begin
        pv[0] <= in_fire;
        pl[0] <= in_fire && in_last;
        pd[0] <= stage_in;
        for (int i = 1; i < CORE_LAT; i++) begin
          pv[i] <= pv[i-1];
          pl[i] <= pl[i-1];
          pd[i] <= pd[i-1];
        end
      end

      if (out_fire) begin
        if (blk_count != '1) blk_count <= blk_count + CNT_W'(1);
        if (mode_q == M_CBC) chain_q <= out_data;
      end

`ifdef ENC_CTR_MODE_EN
      if (in_fire) ctr_q <= ctr_q + CTR_W'(1);
`endif

      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            if (mode_ok) begin
              mode_q    <= cfg_mode;
              key_q     <= cfg_key;
              seed_q    <= cfg_seed;
              iv_q      <= cfg_iv;
              chain_q   <= cfg_iv;
`ifdef ENC_CTR_MODE_EN
              ctr_q     <= cfg_iv[CTR_W-1:0];
`endif
              cfg_err   <= 1'b0;
              blk_count <= '0;
              state     <= S_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_RUN:   if (in_fire && in_last) state <= S_DRAIN;
        S_DRAIN: if (out_fire && out_last) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_encryption_stream_ctrl.sv
// Randomised self-checking bench for encryption_stream_ctrl against a message-level model.
module tb_encryption_stream_ctrl;
  localparam int CORE_LAT = 2;
  localparam int CTR_W    = 32;
  localparam int CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_load;
  logic [1:0]       cfg_mode;
  logic [255:0]     cfg_key;
  logic [255:0]     cfg_seed;
  logic [127:0]     cfg_iv;
  logic             cfg_err;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             out_last;
  logic [CNT_W-1:0] blk_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] m_key, m_seed;
  logic [127:0] m_iv, m_chain;
  logic [31:0]  m_ctr;
  logic [1:0]   m_mode;
  logic [127:0] msg_q [$];

  int first_acc, first_out;
  bit consec;

  encryption_stream_ctrl #(.CORE_LAT(CORE_LAT), .CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
    .cfg_seed(cfg_seed), .cfg_iv(cfg_iv), .cfg_err(cfg_err), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] enc_ref(input logic [127:0] p, input logic [255:0] s,
                                           input logic [255:0] k);
    logic [127:0] x;
    x = p ^ k[127:0];
    x = (x << 9) | (x >> 119);
    return (x + s[127:0]) ^ k[255:128] ^ s[255:128];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [1:0] mode, input logic [255:0] k, input logic [255:0] s,
                          input logic [127:0] iv);
    cfg_mode = mode; cfg_key = k; cfg_seed = s; cfg_iv = iv; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic start_msg(input logic [1:0] mode, input logic [255:0] k, input logic [255:0] s,
                           input logic [127:0] iv);
    m_mode = mode; m_key = k; m_seed = s; m_iv = iv; m_chain = iv; m_ctr = iv[31:0];
    load_cfg(mode, k, s, iv);
  endtask

  // rdy_mode: 0 always ready, 1 random, 2 stalled for cycles 3..7
  task automatic run_msg(input int n, input int vld_pct, input int rdy_mode);
    logic [127:0] exp_d [$];
    bit           exp_l [$];
    logic [127:0] e, held_d;
    bit held, held_l;
    int acc, emit, cyc, inflight, last_acc;
    acc = 0; emit = 0; cyc = 0; held = 0; held_d = '0; held_l = 0; last_acc = -1;
    first_acc = -1; first_out = -1; consec = 1;
    in_valid  = ($urandom_range(99) < vld_pct);
    in_data   = msg_q[0];
    in_last   = (n == 1);
    out_ready = (rdy_mode == 1) ? ($urandom_range(99) < 60) : 1'b1;
    while (emit < n && cyc < 400) begin
      @(negedge clk);
      inflight = acc - emit;
      if (held) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   cyc, out_valid, out_data, out_last, held_d, held_l);
        end
      end
      if (m_mode == 2'b01 && inflight > 0) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL cbc_one_outstanding cyc=%0d in_ready=%b want 0", cyc, in_ready);
        end
      end
      if (acc == n) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL drain_in_ready cyc=%0d in_ready=%b want 0", cyc, in_ready);
        end
      end else if (inflight == 0 || (m_mode != 2'b01 && out_ready)) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL run_in_ready cyc=%0d in_ready=%b want 1", cyc, in_ready);
        end
      end
      if (!out_ready && inflight >= CORE_LAT) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL full_in_ready cyc=%0d in_ready=%b want 0", cyc, in_ready);
        end
      end
      if (first_out < 0 && out_valid === 1'b1) first_out = cyc;
      if (in_valid && in_ready === 1'b1) begin
        case (m_mode)
          2'b01: begin e = enc_ref(in_data ^ m_chain, m_seed, m_key); m_chain = e; end
          2'b10: begin
            e = enc_ref({m_iv[127:32], m_ctr}, m_seed, m_key) ^ in_data;
            m_ctr = m_ctr + 32'd1;
          end
          default: e = enc_ref(in_data, m_seed, m_key);
        endcase
        exp_d.push_back(e);
        exp_l.push_back(acc == n - 1);
        if (acc == 0) first_acc = cyc;
        else if (cyc != last_acc + 1) consec = 0;
        last_acc = cyc;
        acc++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (exp_d.size() == 0) begin
          n_fail++; $display("FAIL extra_output cyc=%0d got %h want none", cyc, out_data);
        end else begin
          if (out_data !== exp_d[0] || out_last !== exp_l[0]) begin
            n_fail++;
            $display("FAIL out_block %0d got d=%h l=%b want d=%h l=%b",
                     emit, out_data, out_last, exp_d[0], exp_l[0]);
          end
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
        end
        emit++;
      end
      held   = (out_valid === 1'b1) && !out_ready;
      held_d = out_data;
      held_l = out_last;
      tick();
      cyc++;
      if (acc < n) begin
        in_valid = ($urandom_range(99) < vld_pct);
        in_data  = msg_q[acc];
        in_last  = (acc == n - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      case (rdy_mode)
        1:       out_ready = ($urandom_range(99) < 60);
        2:       out_ready = !(cyc >= 3 && cyc < 8);
        default: out_ready = 1'b1;
      endcase
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (emit != n) begin
      n_fail++; $display("FAIL msg_timeout emitted=%0d want %0d", emit, n);
      rst = 1'b1; tick(); tick(); rst = 1'b0;
    end
  endtask

  task automatic check_idle_after(input int n);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || blk_count !== CNT_W'(n)) begin
      n_fail++;
      $display("FAIL msg_end busy=%b blk_count=%0d want busy=0 blk_count=%0d", busy, blk_count, n);
    end
    tick();
  endtask

  task automatic fill_random(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(rnd128());
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 0 || in_ready !== 0 || busy !== 0 || cfg_err !== 0 || out_last !== 0 ||
        out_data !== '0 || blk_count !== '0) begin
      n_fail++;
      $display("FAIL reset_values v=%b rdy=%b busy=%b err=%b last=%b d=%h cnt=%0d want all 0",
               out_valid, in_ready, busy, cfg_err, out_last, out_data, blk_count);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_ecb();
    logic [255:0] k;
    for (int i = 0; i < 32; i++) k[255 - 8*i -: 8] = 8'(i);
    msg_q.delete();
    msg_q.push_back(128'habcdefadcdef01234567890123456789);
    msg_q.push_back(128'h0);
    msg_q.push_back({128{1'b1}});
    start_msg(2'b00, k, k, '0);
    run_msg(3, 100, 0);
    n_checks++;
    if (first_out - first_acc != CORE_LAT) begin
      n_fail++; $display("FAIL ecb_latency got %0d want %0d", first_out - first_acc, CORE_LAT);
    end
    n_checks++;
    if (consec !== 1'b1) begin
      n_fail++; $display("FAIL ecb_back_to_back got gaps want consecutive accepts");
    end
    check_idle_after(3);
  endtask

  task automatic test_cbc();
    logic [127:0] iv;
    for (int i = 0; i < 16; i++) iv[127 - 8*i -: 8] = 8'(i);
    fill_random(2);
    start_msg(2'b01, rnd256(), rnd256(), iv);
    run_msg(2, 100, 0);
    check_idle_after(2);
  endtask

`ifdef ENC_CTR_MODE_EN
  task automatic test_ctr();
    fill_random(2);
    start_msg(2'b10, rnd256(), rnd256(), 128'h00112233445566778899aabbffffffff);
    run_msg(2, 100, 0);
    check_idle_after(2);
  endtask
`else
  task automatic test_ctr();
    load_cfg(2'b10, rnd256(), rnd256(), rnd128());
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ctr_disabled err=%b busy=%b want err=1 busy=0", cfg_err, busy);
    end
    tick();
  endtask
`endif

  task automatic test_backpressure();
    fill_random(8);
    start_msg(2'b00, rnd256(), rnd256(), rnd128());
    run_msg(8, 100, 2);
    check_idle_after(8);
  endtask

  task automatic test_cfg_guard();
    load_cfg(2'b11, rnd256(), rnd256(), rnd128());
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL cfg_reserved err=%b busy=%b want err=1 busy=0", cfg_err, busy);
    end
    tick();
    fill_random(4);
    start_msg(2'b00, rnd256(), rnd256(), rnd128());
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL cfg_legal err=%b busy=%b want err=0 busy=1", cfg_err, busy);
    end
    tick();
    load_cfg(2'b01, rnd256(), rnd256(), rnd128());
    run_msg(4, 100, 0);
    check_idle_after(4);
  endtask

  task automatic test_random_msgs();
    logic [1:0] mode;
    int n;
    for (int t = 0; t < 6; t++) begin
`ifdef ENC_CTR_MODE_EN
      mode = 2'($urandom_range(2));
`else
      mode = 2'($urandom_range(1));
`endif
      n = $urandom_range(1, 7);
      fill_random(n);
      start_msg(mode, rnd256(), rnd256(), rnd128());
      run_msg(n, 70, 1);
      check_idle_after(n);
    end
  endtask

  task automatic test_reset_midrun();
    fill_random(4);
    start_msg(2'b00, rnd256(), rnd256(), rnd128());
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    for (int i = 0; i < 3; i++) begin in_data = msg_q[i]; tick(); end
    rst = 1'b1; tick(); tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 0 || in_ready !== 0 || busy !== 0 || cfg_err !== 0 || blk_count !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset v=%b rdy=%b busy=%b err=%b cnt=%0d want all 0",
               out_valid, in_ready, busy, cfg_err, blk_count);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_quiet cyc=%0d v=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_load = 0; cfg_mode = 0; cfg_key = '0; cfg_seed = '0; cfg_iv = '0;
    in_valid = 0; in_data = '0; in_last = 0; out_ready = 1'b1;
    #1;
    test_reset();
    test_ecb();
    test_cbc();
    test_ctr();
    test_backpressure();
    test_cfg_guard();
    test_random_msgs();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
